// File: rtl/axi_riscv_lrsc_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_riscv_lrsc_mem_pkg
// Shared types for the LR/SC-aware AXI4 word memory:
//   - AXI response codes
//   - res_t: one reservation entry {valid, id, idx}. The id and idx fields are
//     sized for the widest configuration. Narrower instances zero-extend into
//     these fields.
//   - w_state_e / r_state_e: write and read channel FSM states
// -----------------------------------------------------------------------------
package axi_riscv_lrsc_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned RES_ID_WIDTH  = 16;
    localparam int unsigned RES_IDX_WIDTH = 32;

    typedef struct packed {
        logic                     valid;
        logic [RES_ID_WIDTH-1:0]  id;
        logic [RES_IDX_WIDTH-1:0] idx;
    } res_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_riscv_lrsc_mem_res.sv
// -----------------------------------------------------------------------------
// axi_riscv_lrsc_mem_res
// Reservation table for LR/SC.
//   set_i/set_id_i/set_idx_i : an LR was accepted, so record {id, idx}
//   chk_id_i/chk_idx_i       : the SC under commit. chk_ok_o is high when a
//                              matching valid reservation exists.
//   clr_i/clr_idx_i          : a write landed (plain or successful SC), so drop
//                              every reservation on that word index
// Optional build macro AXI_RISCV_LRSC_MEM_PER_ID_RES_EN:
//   defined   -> one entry per AXI ID, indexed by ID
//   undefined -> a single global entry that any LR overwrites
// The top never raises set and clr in the same cycle. If both were raised, set
// would win for its own entry.
// -----------------------------------------------------------------------------
module axi_riscv_lrsc_mem_res
    import axi_riscv_lrsc_mem_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned IDX_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_i,
    input  logic [ID_WIDTH-1:0]  set_id_i,
    input  logic [IDX_WIDTH-1:0] set_idx_i,
    input  logic [ID_WIDTH-1:0]  chk_id_i,
    input  logic [IDX_WIDTH-1:0] chk_idx_i,
    output logic                 chk_ok_o,
    input  logic                 clr_i,
    input  logic [IDX_WIDTH-1:0] clr_idx_i
);

    res_t set_entry_s;

    // Build the entry an accepted LR installs.
    always_comb begin
        set_entry_s       = '0;
        set_entry_s.valid = 1'b1;
        set_entry_s.id    = RES_ID_WIDTH'(set_id_i);
        set_entry_s.idx   = RES_IDX_WIDTH'(set_idx_i);
    end

`ifdef AXI_RISCV_LRSC_MEM_PER_ID_RES_EN
    localparam int unsigned NUM_ENTRIES = 2 ** ID_WIDTH;

    res_t res_r [NUM_ENTRIES];
    res_t chk_entry_s;

    assign chk_entry_s = res_r[chk_id_i];
    assign chk_ok_o    = chk_entry_s.valid
                      && (chk_entry_s.id  == RES_ID_WIDTH'(chk_id_i))
                      && (chk_entry_s.idx == RES_IDX_WIDTH'(chk_idx_i));

    // Per-ID table: clear every entry on the written word, then install the LR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                res_r[e] <= '0;
            end
        end else begin
            if (clr_i) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (res_r[e].valid && (res_r[e].idx == RES_IDX_WIDTH'(clr_idx_i))) begin
                        res_r[e].valid <= 1'b0;
                    end
                end
            end
            if (set_i) begin
                res_r[set_id_i] <= set_entry_s;
            end
        end
    end
`else
    res_t res_r;

    assign chk_ok_o = res_r.valid
                   && (res_r.id  == RES_ID_WIDTH'(chk_id_i))
                   && (res_r.idx == RES_IDX_WIDTH'(chk_idx_i));

    // Single global reservation: any LR replaces it, and a write on its word drops it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_r <= '0;
        end else if (set_i) begin
            res_r <= set_entry_s;
        end else if (clr_i && res_r.valid && (res_r.idx == RES_IDX_WIDTH'(clr_idx_i))) begin
            res_r.valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/axi_riscv_lrsc_mem.sv
// -----------------------------------------------------------------------------
// axi_riscv_lrsc_mem
// Terminating AXI4 subordinate. It is an on-chip word memory that serves
// RISC-V LR/SC directly as AXI exclusive accesses. Every transaction is a
// single beat of the full bus width.
//   AW/W/B : write channel. aw_lock=1 marks an SC. The write goes through the
//            FSM W_IDLE -> W_DATA -> W_RESP.
//   AR/R   : read channel. ar_lock=1 marks an LR. The read goes through the
//            FSM R_IDLE -> R_RESP.
//   Responses: OKAY, EXOKAY (LR, or an SC that succeeds), or DECERR for
//   addresses at or above NUM_WORDS*AXI_STRB_WIDTH.
// The cycle where the W beat is accepted is the commit cycle. ar_ready is low
// in that cycle, so a read never samples memory while the same cycle writes it.
// Optional build macro AXI_RISCV_LRSC_MEM_PER_ID_RES_EN selects one
// reservation per AXI ID. The default is a single global reservation.
// -----------------------------------------------------------------------------
module axi_riscv_lrsc_mem
    import axi_riscv_lrsc_mem_pkg::*;
#(
    parameter  int unsigned AXI_ADDR_WIDTH = 32,
    parameter  int unsigned AXI_DATA_WIDTH = 64,
    parameter  int unsigned AXI_ID_WIDTH   = 4,
    parameter  int unsigned NUM_WORDS      = 256,
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0] slv_aw_addr_i,
    input  logic                      slv_aw_lock_i,
    input  logic [AXI_ID_WIDTH-1:0]   slv_aw_id_i,
    input  logic                      slv_aw_valid_i,
    output logic                      slv_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] slv_ar_addr_i,
    input  logic                      slv_ar_lock_i,
    input  logic [AXI_ID_WIDTH-1:0]   slv_ar_id_i,
    input  logic                      slv_ar_valid_i,
    output logic                      slv_ar_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] slv_w_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] slv_w_strb_i,
    input  logic                      slv_w_valid_i,
    output logic                      slv_w_ready_o,
    output logic [AXI_DATA_WIDTH-1:0] slv_r_data_o,
    output logic [1:0]                slv_r_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   slv_r_id_o,
    output logic                      slv_r_valid_o,
    input  logic                      slv_r_ready_i,
    output logic [1:0]                slv_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   slv_b_id_o,
    output logic                      slv_b_valid_o,
    input  logic                      slv_b_ready_i
);

    localparam int unsigned OFF_WIDTH = $clog2(AXI_STRB_WIDTH);
    localparam int unsigned IDX_WIDTH = $clog2(NUM_WORDS);
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES =
        (AXI_ADDR_WIDTH + 1)'(NUM_WORDS * AXI_STRB_WIDTH);

    // All address bits take part, so a high bit never aliases back into the array.
    function automatic logic addr_out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} >= MEM_BYTES);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem_r [NUM_WORDS];

    // Write channel state
    w_state_e                  w_state_r;
    logic                      aw_ready_r;
    logic                      w_ready_r;
    logic                      b_valid_r;
    logic [1:0]                b_resp_r;
    logic [AXI_ID_WIDTH-1:0]   b_id_r;
    logic [IDX_WIDTH-1:0]      wr_idx_r;
    logic [AXI_ID_WIDTH-1:0]   wr_id_r;
    logic                      wr_lock_r;
    logic                      wr_oor_r;

    // Read channel state
    r_state_e                  r_state_r;
    logic                      ar_ready_r;
    logic                      r_valid_r;
    logic [AXI_DATA_WIDTH-1:0] r_data_r;
    logic [1:0]                r_resp_r;
    logic [AXI_ID_WIDTH-1:0]   r_id_r;

    logic                      commit_s;
    logic                      sc_ok_s;
    logic                      wr_en_s;
    logic [1:0]                wr_resp_s;
    logic                      ar_hs_s;
    logic                      ar_oor_s;
    logic [IDX_WIDTH-1:0]      ar_idx_s;
    logic [IDX_WIDTH-1:0]      aw_idx_s;

    assign aw_idx_s = slv_aw_addr_i[OFF_WIDTH +: IDX_WIDTH];
    assign ar_idx_s = slv_ar_addr_i[OFF_WIDTH +: IDX_WIDTH];
    assign ar_oor_s = addr_out_of_range(slv_ar_addr_i);
    assign commit_s = w_ready_r & slv_w_valid_i;
    assign ar_hs_s  = slv_ar_valid_i & ar_ready_r & ~commit_s;

    assign slv_aw_ready_o = aw_ready_r;
    assign slv_w_ready_o  = w_ready_r;
    assign slv_b_valid_o  = b_valid_r;
    assign slv_b_resp_o   = b_resp_r;
    assign slv_b_id_o     = b_id_r;
    assign slv_ar_ready_o = ar_ready_r & ~commit_s;
    assign slv_r_valid_o  = r_valid_r;
    assign slv_r_data_o   = r_data_r;
    assign slv_r_resp_o   = r_resp_r;
    assign slv_r_id_o     = r_id_r;

    axi_riscv_lrsc_mem_res #(
        .ID_WIDTH  (AXI_ID_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_res (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_i     (ar_hs_s & slv_ar_lock_i & ~ar_oor_s),
        .set_id_i  (slv_ar_id_i),
        .set_idx_i (ar_idx_s),
        .chk_id_i  (wr_id_r),
        .chk_idx_i (wr_idx_r),
        .chk_ok_o  (sc_ok_s),
        .clr_i     (wr_en_s),
        .clr_idx_i (wr_idx_r)
    );

    // Decide the outcome of the latched write. A failed SC leaves memory and
    // the reservation untouched. A zero-strobe write still counts as a write.
    always_comb begin
        wr_resp_s = RESP_OKAY;
        wr_en_s   = 1'b0;
        if (wr_oor_r) begin
            wr_resp_s = RESP_DECERR;
            wr_en_s   = 1'b0;
        end else if (wr_lock_r) begin
            wr_resp_s = sc_ok_s ? RESP_EXOKAY : RESP_OKAY;
            wr_en_s   = commit_s & sc_ok_s;
        end else begin
            wr_resp_s = RESP_OKAY;
            wr_en_s   = commit_s;
        end
    end

    // Byte-masked memory write in the commit cycle. Reset does not clear the contents.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (slv_w_strb_i[b]) begin
                    mem_r[wr_idx_r][b*8 +: 8] <= slv_w_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: accept AW, then W (commit), then hold B until it is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_r  <= W_IDLE;
            aw_ready_r <= 1'b1;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= RESP_OKAY;
            b_id_r     <= '0;
            wr_idx_r   <= '0;
            wr_id_r    <= '0;
            wr_lock_r  <= 1'b0;
            wr_oor_r   <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (slv_aw_valid_i) begin
                        wr_idx_r   <= aw_idx_s;
                        wr_id_r    <= slv_aw_id_i;
                        wr_lock_r  <= slv_aw_lock_i;
                        wr_oor_r   <= addr_out_of_range(slv_aw_addr_i);
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b1;
                        w_state_r  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (slv_w_valid_i) begin
                        w_ready_r <= 1'b0;
                        b_valid_r <= 1'b1;
                        b_resp_r  <= wr_resp_s;
                        b_id_r    <= wr_id_r;
                        w_state_r <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (slv_b_ready_i) begin
                        b_valid_r  <= 1'b0;
                        aw_ready_r <= 1'b1;
                        w_state_r  <= W_IDLE;
                    end
                end
                default: begin
                    aw_ready_r <= 1'b1;
                    w_ready_r  <= 1'b0;
                    b_valid_r  <= 1'b0;
                    w_state_r  <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: sample memory on the AR handshake, then hold R until it is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b1;
            r_valid_r  <= 1'b0;
            r_data_r   <= '0;
            r_resp_r   <= RESP_OKAY;
            r_id_r     <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_data_r   <= ar_oor_s ? '0 : mem_r[ar_idx_s];
                        r_resp_r   <= ar_oor_s      ? RESP_DECERR :
                                      slv_ar_lock_i ? RESP_EXOKAY : RESP_OKAY;
                        r_id_r     <= slv_ar_id_i;
                        r_valid_r  <= 1'b1;
                        ar_ready_r <= 1'b0;
                        r_state_r  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (slv_r_ready_i) begin
                        r_valid_r  <= 1'b0;
                        ar_ready_r <= 1'b1;
                        r_state_r  <= R_IDLE;
                    end
                end
                default: begin
                    r_valid_r  <= 1'b0;
                    ar_ready_r <= 1'b1;
                    r_state_r  <= R_IDLE;
                end
            endcase
        end
    end

endmodule
